image_stride_buffer: RTL and testbench
======================================

Name: image_stride_buffer

Overview:
- Parametrised, inferred-RAM successor to the fixed-depth stride FIFO in the image path.
- Sits between the image feature-map producer and the convolution window logic.
- Optional stride-2 decimation on the write side: keeps even columns of even rows only.
- Registered watermark flags for both sides: M_Ready tells the consumer enough data is present; S_Ready tells the producer enough space remains.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_BITS, 11, log2 of depth; DEPTH = 2**ADDR_BITS words.
- COL_BITS, 12, width of the row-length input.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  WIDTH  write data.
- wr_en  in  1  write request (one pixel).
- frame_start  in  1  pulse; restarts column/row decimation counters.
- stride_en  in  1  1 = stride-2 decimation, 0 = pass all writes; quasi-static.
- col_num  in  COL_BITS  input pixels per row; quasi-static.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data, registered.
- dout_valid  out  1  dout holds newly popped word.
- data_count  out  ADDR_BITS+1  stored word count, 0..DEPTH.
- empty  out  1  data_count == 0.
- full  out  1  data_count == DEPTH.
- overflow  out  1  sticky: an accepted write was dropped because the buffer was full.
- M_count  in  ADDR_BITS+1  consumer threshold.
- M_Ready  out  1  registered: data_count >= M_count.
- S_count  in  ADDR_BITS+1  producer burst size.
- S_Ready  out  1  registered: data_count + S_count <= DEPTH.

Behaviour:
- Reset values, synchronous on rst=1: pointers 0, data_count 0, empty 1, full 0, dout 0, dout_valid 0, overflow 0, M_Ready 0, S_Ready 1, col_cnt 0, row_par 0.
- Reset mid-operation discards all contents; the RAM array itself is not cleared.
- Decimation:
  - The counters advance on every wr_en, whether the word is kept or not.
  - col_cnt increments; at col_cnt == col_num-1 it wraps to 0 and row_par toggles.
  - col_num of 0 or 1 makes every write end a row.
  - accept = !stride_en | (col_cnt[0]==0 & row_par==0).
- frame_start:
  - Clears col_cnt and row_par.
  - If wr_en is high in the same cycle, that write is treated as column 0 of row 0 (accepted) and then advances the counters from that state.
- Write: push = wr_en & accept & (!full | pop); data goes to wr_ptr, which increments mod DEPTH.
- Overflow: wr_en & accept & full & !pop sets overflow; only rst clears it.
- Read:
  - pop = rd_en & !empty.
  - dout <= RAM[rd_ptr] on the next edge and dout_valid=1 for exactly that cycle.
  - rd_ptr increments mod DEPTH.
  - rd_en while empty is ignored: dout is held and dout_valid=0.
- Count update: data_count += push - pop.
  - Simultaneous push and pop leaves the count unchanged, including at full and at empty.
  - empty and full are decoded from data_count.
- Latency:
  - Write to empty deasserts on the cycle after the push.
  - Earliest read data is 2 cycles after the write.
- Pointers wrap naturally at ADDR_BITS bits; data_count disambiguates full from empty.
- Watermarks:
  - Computed from the registered data_count, so they lag it by one cycle.
  - The S_Ready sum is computed at ADDR_BITS+2 bits; there is no truncation.
  - M_count = 0 gives M_Ready=1 one cycle after reset release.
  - S_count > DEPTH forces S_Ready=0.

Decomposition:
- Shared package image_pkg holds:
  - stride mode constants STRIDE_1=0 and STRIDE_2=1;
  - a function for the S_Ready width, ADDR_BITS+2.
- One sub-module, image_stride_ram: a simple dual-port inferred RAM (WIDTH x DEPTH) with a synchronous registered read.
- Pointers, counts, flags and decimation logic live in the top module.

Test Plan:
- Fill and drain (ADDR_BITS=4, stride_en=0, M_count=16, S_count=1):
  - Write 16 words → full=1, data_count=16, S_Ready=0 one cycle later, M_Ready=1.
  - Read 16 → dout follows the write order, empty=1.
- Overflow: a 17th write while full with rd_en=0 → data_count stays 16, overflow=1 and remains set until rst.
- Stride-2 (col_num=4, stride_en=1, frame_start with the first write):
  - Stream 16 pixels 0..15 → exactly 4 stored: 0, 2, 8, 10.
- Simultaneous read and write:
  - At full: push and pop same cycle → data_count stays 16, overflow=0.
  - At empty: the write proceeds, the read is ignored, dout_valid=0.
- Watermark boundaries (ADDR_BITS=4):
  - data_count=10, S_count=6 → S_Ready=1; S_count=7 → S_Ready=0.
  - M_count=10 → M_Ready=1 at count 10, 0 at count 9.
- Reset mid-stream: rst pulsed with data_count=7 and stride counters mid-row → next cycle all outputs at reset values, next write stored at address 0.

Source files
------------

// File: rtl/image_pkg.sv
`default_nettype none
// ============================================================================
// Package     : image_pkg
// Description : Shared constants and helpers for the image stride buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package image_pkg;

    localparam logic STRIDE_1 = 1'b0;
    localparam logic STRIDE_2 = 1'b1;

    // Room for count + burst size without wrap, so large bursts never alias small.
    function automatic int sready_width(input int addr_bits);
        return addr_bits + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_stride_ram.sv
`default_nettype none
// ============================================================================
// Module      : image_stride_ram
// Description : Simple dual-port inferred RAM with a registered, resettable read.
// Revision    : 1.0 - initial release
// ============================================================================
module image_stride_ram #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write on a shared address, so a pop at full sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (i_rd_en) begin
            rd_data_q <= mem[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/image_stride_buffer.sv
`default_nettype none
// ============================================================================
// Module      : image_stride_buffer
// Description : Inferred-RAM FIFO with optional stride-2 write decimation and
//               registered producer/consumer watermark flags.
// Revision    : 1.0 - initial release
// ============================================================================
module image_stride_buffer
    import image_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 11,
    parameter int COL_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 frame_start,
    input  logic                 stride_en,
    input  logic [COL_BITS-1:0]  col_num,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic [ADDR_BITS:0]   data_count,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow,
    input  logic [ADDR_BITS:0]   M_count,
    output logic                 M_Ready,
    input  logic [ADDR_BITS:0]   S_count,
    output logic                 S_Ready
);

    localparam int                   c_sw        = sready_width(ADDR_BITS);
    localparam logic [ADDR_BITS:0]   c_cnt_one   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0]   c_cnt_depth = (ADDR_BITS+1)'(2**ADDR_BITS);
    localparam logic [ADDR_BITS-1:0] c_ptr_one   = ADDR_BITS'(1);
    localparam logic [COL_BITS-1:0]  c_col_one   = COL_BITS'(1);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [COL_BITS-1:0]  col_cnt_q, col_cnt_d;
    logic                 row_par_q, row_par_d;
    logic                 overflow_q, overflow_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 m_ready_q, m_ready_d;
    logic                 s_ready_q, s_ready_d;

    logic [COL_BITS-1:0]  col_eff, col_last;
    logic                 par_eff, row_end, accept, push, pop;
    logic [c_sw-1:0]      s_sum;

    assign empty = (count_q == '0);
    assign full  = (count_q == c_cnt_depth);

    always_comb begin
        col_eff  = frame_start ? '0 : col_cnt_q;
        par_eff  = frame_start ? 1'b0 : row_par_q;
        col_last = col_num - c_col_one;
        row_end  = (col_num <= c_col_one) || (col_eff == col_last);
        accept   = (stride_en == STRIDE_1) || (!col_eff[0] && !par_eff);

        pop  = rd_en && !empty;
        push = wr_en && accept && (!full || pop);

        col_cnt_d = col_cnt_q;
        row_par_d = row_par_q;
        if (wr_en) begin
            col_cnt_d = row_end ? '0 : col_eff + c_col_one;
            row_par_d = row_end ? !par_eff : par_eff;
        end else if (frame_start) begin
            col_cnt_d = '0;
            row_par_d = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + c_ptr_one : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + c_ptr_one : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase

        overflow_d   = overflow_q || (wr_en && accept && full && !pop);
        dout_valid_d = pop;

        // Watermarks look at the registered count, hence the one-cycle lag.
        s_sum     = c_sw'(count_q) + c_sw'(S_count);
        m_ready_d = (count_q >= M_count);
        s_ready_d = (s_sum <= c_sw'(c_cnt_depth));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            col_cnt_q    <= '0;
            row_par_q    <= 1'b0;
            overflow_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            m_ready_q    <= 1'b0;
            s_ready_q    <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            col_cnt_q    <= col_cnt_d;
            row_par_q    <= row_par_d;
            overflow_q   <= overflow_d;
            dout_valid_q <= dout_valid_d;
            m_ready_q    <= m_ready_d;
            s_ready_q    <= s_ready_d;
        end
    end

    image_stride_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (push),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (din),
        .i_rd_en   (pop),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (dout)
    );

    assign dout_valid = dout_valid_q;
    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign M_Ready    = m_ready_q;
    assign S_Ready    = s_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_image_stride_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_stride_buffer
// Description : Directed scoreboard bench for image_stride_buffer (depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_stride_buffer;

    localparam int WIDTH = 8;
    localparam int AB    = 4;
    localparam int CB    = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [WIDTH-1:0] din;
    logic            wr_en, frame_start, stride_en, rd_en;
    logic [CB-1:0]   col_num;
    logic [WIDTH-1:0] dout;
    logic            dout_valid, empty, full, overflow, M_Ready, S_Ready;
    logic [AB:0]     data_count, M_count, S_count;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q [$];

    always #5 clk = ~clk;

    image_stride_buffer #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (AB),
        .COL_BITS  (CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .frame_start (frame_start),
        .stride_en   (stride_en),
        .col_num     (col_num),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .data_count  (data_count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .M_count     (M_count),
        .M_Ready     (M_Ready),
        .S_count     (S_count),
        .S_Ready     (S_Ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        din   = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [WIDTH-1:0] e);
        exp_q.push_back(e);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},      int'(data_count), 0);
        chk({tag, "_empty"},      int'(empty), 1);
        chk({tag, "_full"},       int'(full), 0);
        chk({tag, "_dout"},       int'(dout), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_overflow"},   int'(overflow), 0);
        chk({tag, "_m_ready"},    int'(M_Ready), 0);
        chk({tag, "_s_ready"},    int'(S_Ready), 1);
    endtask

    // Monitor: every presented word must match the oldest expectation.
    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                chk("dout_unexpected", int'(dout), -1);
            end else begin
                chk("dout", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din = '0; wr_en = 0; frame_start = 0; stride_en = 0; rd_en = 0;
        col_num = 12'd4; M_count = 5'd16; S_count = 5'd1;
        step(); step();
        chk_reset_state("reset");
        rst = 1'b0;

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            wr(8'hA0 + 8'(i));
            if (i == 0) chk("empty_after_first_write", int'(empty), 0);
        end
        chk("fill_count", int'(data_count), 16);
        chk("fill_full", int'(full), 1);
        chk("s_ready_lag", int'(S_Ready), 1);
        step();
        chk("fill_s_ready", int'(S_Ready), 0);
        chk("fill_m_ready", int'(M_Ready), 1);

        // Push and pop together at full
        din = 8'hB0; wr_en = 1'b1;
        rd(8'hA0);
        wr_en = 1'b0;
        chk("full_rw_count", int'(data_count), 16);
        chk("full_rw_overflow", int'(overflow), 0);

        // Overflow is sticky
        wr(8'hFF);
        chk("ovf_count", int'(data_count), 16);
        chk("ovf_set", int'(overflow), 1);
        step();
        chk("ovf_sticky", int'(overflow), 1);

        // Drain in write order
        for (int i = 1; i < 16; i++) rd(8'hA0 + 8'(i));
        rd(8'hB0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_count", int'(data_count), 0);
        chk("drain_ovf_sticky", int'(overflow), 1);

        // Read and write together at empty: the read is ignored
        din = 8'hC5; wr_en = 1'b1; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("empty_rw_valid", int'(dout_valid), 0);
        chk("empty_rw_count", int'(data_count), 1);
        chk("empty_rw_dout_held", int'(dout), 8'hB0);
        rd(8'hC5);

        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_clears_ovf", int'(overflow), 0);

        // Stride-2, 4 columns per row
        stride_en = 1'b1; col_num = 12'd4;
        for (int i = 0; i < 16; i++) begin
            frame_start = (i == 0);
            wr(8'(i));
        end
        frame_start = 1'b0;
        chk("stride_count", int'(data_count), 4);
        rd(8'd0); rd(8'd2); rd(8'd8); rd(8'd10);
        chk("stride_empty", int'(empty), 1);

        // Watermark boundaries
        stride_en = 1'b0; M_count = 5'd10; S_count = 5'd6;
        for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i));
        step();
        chk("wm_count", int'(data_count), 10);
        chk("wm_s6", int'(S_Ready), 1);
        chk("wm_m10", int'(M_Ready), 1);
        S_count = 5'd7;
        step();
        chk("wm_s7", int'(S_Ready), 0);
        rd(8'h10);
        chk("wm_count9", int'(data_count), 9);
        chk("wm_m_lag", int'(M_Ready), 1);
        step();
        chk("wm_m9", int'(M_Ready), 0);
        chk("wm_s7_at9", int'(S_Ready), 1);
        S_count = 5'd31;
        step();
        chk("wm_s31_no_trunc", int'(S_Ready), 0);

        // Reset mid-stream with seven words stored and counters mid-row
        rd(8'h11); rd(8'h12);
        chk("pre_rst_count", int'(data_count), 7);
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset_state("midrst");

        stride_en = 1'b1; S_count = 5'd1;
        wr(8'h77);
        wr(8'h78);
        chk("post_rst_count", int'(data_count), 1);
        chk("post_rst_wr_ptr", int'(dut.wr_ptr_q), 1);
        rd(8'h77);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
